mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the data width of each requester and of the shared output.
REQ-002 Parameter MAX_HOLD, default 4, is the maximum consecutive owned cycles before forced hand-off (used only with ARB_TIMEOUT_EN).
REQ-003 Port clk  input  1  is the single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  is the reset: synchronous, active-high.
REQ-005 Port req_a  input  1  is requester A holding request; high = wants ownership.
REQ-006 Port req_b  input  1  is requester B holding request.
REQ-007 Port data_a  input  WIDTH  is requester A data.
REQ-008 Port data_b  input  WIDTH  is requester B data.
REQ-009 Port gnt_a  output  1  is registered grant to A.
REQ-010 Port gnt_b  output  1  is registered grant to B.
REQ-011 Port sel  output  1  is the registered shared-mux select: 0 = A, 1 = B.
REQ-012 Port out  output  WIDTH  is registered shared-mux output.
REQ-013 Port out_valid  output  1  is high when out carries an owner's data.

Function
REQ-014 States SHALL be IDLE, OWN_A, OWN_B; internal last_owner bit (0 = A, 1 = B).
REQ-015 gnt_a SHALL be high exactly in OWN_A, gnt_b exactly in OWN_B; never both high.
REQ-016 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> owner opposite last_owner; neither -> stay IDLE.
REQ-017 Grant latency SHALL be 1 cycle: request sampled high at edge k -> gnt high after edge k.
REQ-018 OWN_A: req_a high -> stay (subject to REQ-026); req_a low and req_b high -> OWN_B directly, no IDLE bubble; both low -> IDLE. OWN_B symmetric.
REQ-019 On leaving OWN_x, last_owner SHALL be set to x.
REQ-020 sel SHALL equal 0 in OWN_A, 1 in OWN_B, and hold its previous value in IDLE.
REQ-021 At each edge: state OWN_A -> out <= data_a, out_valid <= 1; OWN_B -> out <= data_b, out_valid <= 1; IDLE -> out holds, out_valid <= 0.
REQ-022 out/out_valid SHALL therefore lag gnt by exactly 1 cycle.
REQ-023 Requests SHALL be level-sensitive; a requester deasserting with no grant is simply ignored.

Reset
REQ-024 reset high at an edge SHALL force IDLE, last_owner = B (A wins first tie), gnt_a = gnt_b = 0, sel = 0, out = 0, out_valid = 0, hold counter = 0; reset dominates all other inputs, including mid-ownership.
REQ-025 After reset release, arbitration SHALL resume from IDLE at the first edge with reset low.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL count owned cycles, clear on every grant change, and when the owner has held MAX_HOLD cycles while the other side requests, the next state SHALL be the other owner regardless of the current owner's request.
REQ-027 ARB_TIMEOUT_EN undefined: no counter SHALL be built, and an owner SHALL keep the grant as long as its request stays high.

Verification
REQ-028 reset high 2 cycles, then req_a=req_b=0 -> gnt_a=gnt_b=0, sel=0, out=0, out_valid=0.
REQ-029 req_a=1 at edge 0, data_a=8'h5A -> gnt_a=1 after edge 0; out=8'h5A, out_valid=1 after edge 1.
REQ-030 From IDLE after reset, req_a=req_b=1 same edge -> A granted; A drops req -> B granted next cycle, sel=1, no IDLE cycle.
REQ-031 A released last, both request again from IDLE -> B granted (round-robin).
REQ-032 With ARB_TIMEOUT_EN, MAX_HOLD=4, req_a held high, req_b raised during A ownership -> gnt_a drops after A's 4th owned cycle, gnt_b rises same edge; without the macro gnt_a stays high indefinitely.
REQ-033 reset pulsed 1 cycle during OWN_B -> all outputs zero next edge, then A wins a subsequent tie.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter driving a shared registered mux.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   req_a/b    - level-sensitive holding requests from requesters A and B
//   data_a/b   - requester data, WIDTH bits each
//   gnt_a/b    - registered grants, one-hot or both low
//   sel        - registered mux select (0 = A, 1 = B), holds its value while idle
//   out        - registered mux output, captures the owner's data one cycle after grant
//   out_valid  - high when out carries data captured from an owner
//
// Optional feature: define ARB_TIMEOUT_EN to build a hold counter that forces a
// hand-off once the owner has held the grant for MAX_HOLD cycles while the other
// side is requesting. Without the macro an owner keeps the grant while it requests.
module mux_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnA = 2'd1,
        StOwnB = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   last_owner_q;  // 0 = A, 1 = B
    logic   hold_expired;  // current cycle is the owner's MAX_HOLD-th owned cycle

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    // Owned cycles completed before the current one; saturates at MAX_HOLD-1 so an
    // uncontested owner hands off immediately once the other side starts requesting.
    logic [HoldW-1:0] hold_q;

    assign hold_expired = (hold_q == HoldW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (state_q == StIdle || state_d != state_q) begin
            hold_q <= '0;
        end else if (!hold_expired) begin
            hold_q <= hold_q + 1'b1;
        end
    end
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign hold_expired    = 1'b0;
`endif

    // Next-owner decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_a && req_b) begin
                    // Tie goes to the side that did not own last.
                    state_d = last_owner_q ? StOwnA : StOwnB;
                end else if (req_a) begin
                    state_d = StOwnA;
                end else if (req_b) begin
                    state_d = StOwnB;
                end else begin
                    state_d = StIdle;
                end
            end
            StOwnA: begin
                if (req_a && !(hold_expired && req_b)) begin
                    state_d = StOwnA;
                end else if (req_b) begin
                    state_d = StOwnB;
                end else begin
                    state_d = StIdle;
                end
            end
            StOwnB: begin
                if (req_b && !(hold_expired && req_a)) begin
                    state_d = StOwnB;
                end else if (req_a) begin
                    state_d = StOwnA;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with registered grant/select/data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            sel          <= 1'b0;
            out          <= '0;
            out_valid    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_a   <= (state_d == StOwnA);
            gnt_b   <= (state_d == StOwnB);

            if (state_d == StOwnA) begin
                sel <= 1'b0;
            end else if (state_d == StOwnB) begin
                sel <= 1'b1;
            end

            if (state_q != StIdle && state_d != state_q) begin
                last_owner_q <= (state_q == StOwnB);
            end

            // Data path follows the current owner, so it lags the grant by one cycle.
            case (state_q)
                StOwnA: begin
                    out       <= data_a;
                    out_valid <= 1'b1;
                end
                StOwnB: begin
                    out       <= data_b;
                    out_valid <= 1'b1;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized traffic,
// with a behavioural model feeding an expectation queue drained by a monitor.
module tb_mux_arbiter;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_a = 1'b0;
    logic             req_b = 1'b0;
    logic [WIDTH-1:0] data_a = '0;
    logic [WIDTH-1:0] data_b = '0;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    mux_arbiter #(
        .WIDTH   (WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_a    (req_a),
        .req_b    (req_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             ga;
        logic             gb;
        logic             sl;
        logic             vl;
        logic [WIDTH-1:0] o;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int               m_own   = 0;
    bit               m_last  = 1'b1;  // 0 = A owned last, 1 = B
    bit               m_sel   = 1'b0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_out   = '0;
    int               m_held  = 0;     // owned cycles completed by the current owner

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit ra, input bit rb,
                              input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        int nxt;
        bit mine;
        bit other;
        bit expired;
        if (r) begin
            m_own   = 0;
            m_last  = 1'b1;
            m_sel   = 1'b0;
            m_out   = '0;
            m_valid = 1'b0;
            m_held  = 0;
            return;
        end
        if (m_own == 1) begin
            m_out   = da;
            m_valid = 1'b1;
        end else if (m_own == 2) begin
            m_out   = db;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (m_own == 0) begin
            if (ra && rb) nxt = m_last ? 1 : 2;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
            else          nxt = 0;
        end else begin
            mine    = (m_own == 1) ? ra : rb;
            other   = (m_own == 1) ? rb : ra;
            expired = 1'b0;
`ifdef ARB_TIMEOUT_EN
            expired = (m_held + 1 >= int'(MAX_HOLD));
`endif
            if (mine && !(expired && other)) nxt = m_own;
            else if (other)                  nxt = 3 - m_own;
            else                             nxt = 0;
            if (nxt != m_own) m_last = (m_own == 2);
        end
        if (nxt != 0 && nxt == m_own) m_held = (m_held < int'(MAX_HOLD)) ? m_held + 1 : m_held;
        else                          m_held = 0;
        if (nxt == 1)      m_sel = 1'b0;
        else if (nxt == 2) m_sel = 1'b1;
        m_own = nxt;
    endtask

    // Apply one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic drive(input bit r, input bit ra, input bit rb,
                         input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        exp_t e;
        @(negedge clk);
        reset  = r;
        req_a  = ra;
        req_b  = rb;
        data_a = da;
        data_b = db;
        model_step(r, ra, rb, da, db);
        e.ga = (m_own == 1);
        e.gb = (m_own == 2);
        e.sl = m_sel;
        e.vl = m_valid;
        e.o  = m_out;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every cycle for which an expectation exists.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_gnt_a", 32'(gnt_a), 32'(e.ga));
                check("sb_gnt_b", 32'(gnt_b), 32'(e.gb));
                check("sb_sel", 32'(sel), 32'(e.sl));
                check("sb_out_valid", 32'(out_valid), 32'(e.vl));
                check("sb_out", 32'(out), 32'(e.o));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: time limit reached, queue depth %0d want 0", exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int wait_cycles;
        // Reset for two cycles, then idle.
        drive(1, 0, 0, 8'h11, 8'h22);
        drive(1, 0, 0, 8'h11, 8'h22);
        drive(0, 0, 0, 8'h11, 8'h22);
        settle();
        check("rst_gnt_a", 32'(gnt_a), 32'd0);
        check("rst_gnt_b", 32'(gnt_b), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // Single request: one-cycle grant latency, data one cycle later.
        drive(0, 1, 0, 8'h5A, 8'h00);
        settle();
        check("lat_gnt_a", 32'(gnt_a), 32'd1);
        check("lat_out_valid_early", 32'(out_valid), 32'd0);
        drive(0, 1, 0, 8'h5A, 8'h00);
        settle();
        check("lat_out", 32'(out), 32'h5A);
        check("lat_out_valid", 32'(out_valid), 32'd1);

        // Tie after reset goes to A; A drops and B takes over without an idle bubble.
        drive(1, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 1, 8'hA1, 8'hB1);
        settle();
        check("tie_gnt_a", 32'(gnt_a), 32'd1);
        check("tie_gnt_b", 32'(gnt_b), 32'd0);
        drive(0, 0, 1, 8'hA2, 8'hB2);
        settle();
        check("handoff_gnt_a", 32'(gnt_a), 32'd0);
        check("handoff_gnt_b", 32'(gnt_b), 32'd1);
        check("handoff_sel", 32'(sel), 32'd1);
        check("handoff_out", 32'(out), 32'hA2);

        // B hands to A, A releases to idle, then a tie goes to B.
        drive(0, 1, 0, 8'hA3, 8'hB3);
        drive(0, 0, 0, 8'hA4, 8'hB4);
        settle();
        check("idle_sel_hold", 32'(sel), 32'd0);
        check("idle_gnt_a", 32'(gnt_a), 32'd0);
        drive(0, 1, 1, 8'hA5, 8'hB5);
        settle();
        check("rr_gnt_b", 32'(gnt_b), 32'd1);
        check("rr_gnt_a", 32'(gnt_a), 32'd0);

        // Reset during B ownership clears everything; next tie goes to A.
        drive(1, 1, 1, 8'hA6, 8'hB6);
        settle();
        check("midrst_gnt_b", 32'(gnt_b), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        drive(0, 1, 1, 8'hA7, 8'hB7);
        settle();
        check("midrst_tie_gnt_a", 32'(gnt_a), 32'd1);

        // Contention while A keeps requesting.
        drive(1, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 0, 8'hC0, 8'hD0);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 8'hC1, 8'hD1);
        settle();
        check("hold4_gnt_a", 32'(gnt_a), 32'd1);
        drive(0, 1, 1, 8'hC2, 8'hD2);
        settle();
`ifdef ARB_TIMEOUT_EN
        check("timeout_gnt_a", 32'(gnt_a), 32'd0);
        check("timeout_gnt_b", 32'(gnt_b), 32'd1);
`else
        check("no_timeout_gnt_a", 32'(gnt_a), 32'd1);
        check("no_timeout_gnt_b", 32'(gnt_b), 32'd0);
`endif
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 8'($urandom), 8'($urandom));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        check("drain_queue_depth", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
